serial_port_ctrl: RTL and testbench
===================================

SERIAL_PORT_CTRL -- requirements
Module: serial_port_ctrl

Interface
REQ-001 SHALL have parameter: DEPTH, 8, entries per FIFO (power of two, 2..64).
REQ-002 SHALL have parameter: CW, $clog2(DEPTH)+1, occupancy count width.
REQ-003 SHALL have ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_wr_en  in  1  push cpu_wr_data into TX FIFO
- cpu_wr_data  in  8  byte to transmit
- cpu_rd_en  in  1  pop RX FIFO head
- cpu_rd_data  out  8  popped byte, registered
- cpu_rd_valid  out  1  cpu_rd_data valid this cycle
- tx_count  out  CW  TX FIFO occupancy
- rx_count  out  CW  RX FIFO occupancy
- tx_drop  out  1  sticky, CPU write lost to full TX FIFO
- clr_drop  in  1  clears tx_drop
- serial_in  in  8  incoming byte
- serial_valid_in  in  1  serial_in holds a byte
- serial_ready_in  in  1  sink can accept a byte
- serial_out  out  8  outgoing byte
- serial_rden_out  out  1  one-cycle consume strobe for serial_in
- serial_wren_out  out  1  one-cycle write strobe for serial_out

Function
REQ-004 SHALL accept a CPU write only when tx_count < DEPTH at the start of the cycle.
- An accepted write appears in tx_count the next cycle.
- A write while full SHALL be discarded and SHALL set tx_drop, even if the TX FSM pops in the same cycle.
REQ-005 SHALL implement TX FSM TX_IDLE -> TX_PUSH -> TX_GAP -> TX_IDLE.
- TX_IDLE -> TX_PUSH when the TX FIFO is non-empty and serial_ready_in = 1.
- TX_PUSH SHALL assert serial_wren_out for exactly one cycle with serial_out = FIFO head, and SHALL pop the head.
- TX_GAP lasts one cycle with serial_wren_out = 0, which gives a minimum 3-cycle spacing between bytes.
REQ-006 SHALL implement RX FSM RX_IDLE -> RX_POP -> RX_GAP -> RX_IDLE.
- RX_IDLE -> RX_POP when serial_valid_in = 1 and rx_count < DEPTH.
- RX_POP SHALL assert serial_rden_out for exactly one cycle and SHALL push serial_in sampled at the end of that cycle.
REQ-007 SHALL apply backpressure when the RX FIFO is full: serial_rden_out stays 0 and no byte is lost.
REQ-008 SHALL complete a cpu_rd_en pop with 1-cycle latency:
- Next cycle cpu_rd_valid = 1 and cpu_rd_data = the head at the time of the request.
REQ-009 SHALL treat cpu_rd_en while the RX FIFO is empty as a no-op:
- Next cycle cpu_rd_valid = 0, cpu_rd_data = 8'h00, no pointer change.
REQ-010 SHALL evaluate empty pre-cycle on the RX side, so a simultaneous RX push and CPU read on an empty FIFO SHALL perform the push and return no data.
REQ-011 SHALL allow a simultaneous push and pop on one non-full, non-empty FIFO, leaving the count unchanged.
REQ-012 SHALL wrap pointers modulo DEPTH; counts SHALL saturate at neither end, because REQ-004 and REQ-007 prevent overflow.
REQ-013 SHALL clear tx_drop on clr_drop; if a dropped write and clr_drop occur in the same cycle, set wins.
REQ-014 SHALL leave serial_out at its last value when serial_wren_out = 0.

Reset
REQ-015 SHALL, when reset = 1 at a clock edge, set:
- both FSMs to IDLE and both FIFOs empty;
- tx_count = rx_count = 0;
- tx_drop = 0, cpu_rd_valid = 0;
- cpu_rd_data = 8'h00, serial_out = 8'h00;
- serial_rden_out = 0, serial_wren_out = 0.
REQ-016 SHALL, on reset mid-operation, abort any in-flight TX_PUSH or RX_POP without a strobe in the following cycle, and discard FIFO contents.
REQ-017 SHALL ignore all inputs during a cycle in which reset = 1.

Structure
REQ-018 SHALL place FSM state encodings (2-bit) and the default DEPTH in shared package serial_pkg.
REQ-019 SHALL instantiate sub-module sync_fifo (parameters DEPTH, WIDTH = 8) twice, once for TX and once for RX; the FSMs, drop flag and read register live in serial_port_ctrl.

Verification
REQ-020 Scenarios the bench SHALL cover:
- Write 8'h48, 8'h69 with serial_ready_in = 1 -> serial_wren_out pulses carrying 8'h48 then 8'h69, pulses 3 cycles apart, tx_count returns to 0.
- 9 writes with serial_ready_in = 0, DEPTH = 8 -> tx_count = 8, tx_drop = 1; clr_drop -> tx_drop = 0.
- serial_valid_in held 1 with serial_in = 8'h5A, no CPU reads -> 8 rden pulses, rx_count = 8, then serial_rden_out stays 0.
- Then cpu_rd_en -> next cycle cpu_rd_valid = 1, cpu_rd_data = 8'h5A; a further RX pop follows, restoring rx_count = 8.
- cpu_rd_en on an empty RX FIFO -> cpu_rd_valid = 0, cpu_rd_data = 8'h00.
- Reset asserted during TX_PUSH with 3 bytes queued -> no further wren pulses, tx_count = 0 the cycle after reset.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial port controller: FSM state encodings
// and the default FIFO depth.
package serial_pkg;

  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_PUSH = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_POP  = 2'd1,
    RX_GAP  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head is visible combinationally.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_port_ctrl.sv
// CPU-facing byte port: TX FIFO drained by a paced TX FSM, RX FIFO filled
// by a paced RX FSM, registered CPU read path and sticky TX drop flag.
module serial_port_ctrl
  import serial_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_wr_en,
  input  logic [7:0]    cpu_wr_data,
  input  logic          cpu_rd_en,
  output logic [7:0]    cpu_rd_data,
  output logic          cpu_rd_valid,
  output logic [CW-1:0] tx_count,
  output logic [CW-1:0] rx_count,
  output logic          tx_drop,
  input  logic          clr_drop,
  input  logic [7:0]    serial_in,
  input  logic          serial_valid_in,
  input  logic          serial_ready_in,
  output logic [7:0]    serial_out,
  output logic          serial_rden_out,
  output logic          serial_wren_out
);

  tx_state_e  tx_state_q, tx_state_d;
  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] serial_out_q, serial_out_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       tx_drop_q, tx_drop_d;

  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;

  // Full/empty are the pre-cycle view, so a same-cycle pop never rescues a write.
  assign tx_push = cpu_wr_en && !tx_full;
  assign tx_pop  = (tx_state_q == TX_PUSH);
  assign rx_push = (rx_state_q == RX_POP);
  assign rx_pop  = cpu_rd_en && !rx_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CW(CW)) u_tx_fifo (
    .clk_i   (clock),
    .srst_i  (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (cpu_wr_data),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CW(CW)) u_rx_fifo (
    .clk_i   (clock),
    .srst_i  (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (serial_in),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_comb begin
    tx_state_d   = tx_state_q;
    rx_state_d   = rx_state_q;
    serial_out_d = serial_out_q;
    tx_drop_d    = tx_drop_q;
    rd_valid_d   = rx_pop;
    rd_data_d    = rx_pop ? rx_head : 8'h00;

    case (tx_state_q)
      TX_IDLE: if (!tx_empty && serial_ready_in) tx_state_d = TX_PUSH;
      TX_PUSH: tx_state_d = TX_GAP;
      TX_GAP:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase

    case (rx_state_q)
      RX_IDLE: if (serial_valid_in && !rx_full) rx_state_d = RX_POP;
      RX_POP:  rx_state_d = RX_GAP;
      RX_GAP:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase

    // Head is captured on entry to TX_PUSH and then held between strobes.
    if (tx_state_q == TX_IDLE && tx_state_d == TX_PUSH) serial_out_d = tx_head;

    if (clr_drop) tx_drop_d = 1'b0;
    if (cpu_wr_en && tx_full) tx_drop_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      rx_state_q   <= RX_IDLE;
      serial_out_q <= 8'h00;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      rx_state_q   <= rx_state_d;
      serial_out_q <= serial_out_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  assign serial_wren_out = (tx_state_q == TX_PUSH);
  assign serial_rden_out = (rx_state_q == RX_POP);
  assign serial_out      = serial_out_q;
  assign cpu_rd_data     = rd_data_q;
  assign cpu_rd_valid    = rd_valid_q;
  assign tx_drop         = tx_drop_q;

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Scoreboard bench for serial_port_ctrl: stimulus queues expected TX bytes and
// CPU read responses; a negedge monitor pops and compares them.
module tb_serial_port_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_wr_en;
  logic [7:0]    cpu_wr_data;
  logic          cpu_rd_en;
  logic [7:0]    cpu_rd_data;
  logic          cpu_rd_valid;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          tx_drop;
  logic          clr_drop;
  logic [7:0]    serial_in;
  logic          serial_valid_in;
  logic          serial_ready_in;
  logic [7:0]    serial_out;
  logic          serial_rden_out;
  logic          serial_wren_out;

  serial_port_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_wr_en       (cpu_wr_en),
    .cpu_wr_data     (cpu_wr_data),
    .cpu_rd_en       (cpu_rd_en),
    .cpu_rd_data     (cpu_rd_data),
    .cpu_rd_valid    (cpu_rd_valid),
    .tx_count        (tx_count),
    .rx_count        (rx_count),
    .tx_drop         (tx_drop),
    .clr_drop        (clr_drop),
    .serial_in       (serial_in),
    .serial_valid_in (serial_valid_in),
    .serial_ready_in (serial_ready_in),
    .serial_out      (serial_out),
    .serial_rden_out (serial_rden_out),
    .serial_wren_out (serial_wren_out)
  );

  always #5 clock = ~clock;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         rden_cnt = 0;
  int         last_wren_cyc = -100;
  int         last_gap = 0;
  logic       rd_req_q = 1'b0;
  logic [7:0] exp_tx [$];
  logic [8:0] exp_rd [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rd_req_q <= cpu_rd_en && !reset;
  end

  // Monitor: every strobe / read response is matched against the scoreboard.
  always @(negedge clock) begin
    logic [7:0] e_tx;
    logic [8:0] e_rd;
    int         gap;
    if (serial_wren_out) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got wren with %0h expected no strobe (cycle %0d)", serial_out, cyc);
      end else begin
        e_tx = exp_tx.pop_front();
        chk("tx_byte", {24'd0, serial_out}, {24'd0, e_tx});
      end
      gap = cyc - last_wren_cyc;
      chk("tx_spacing_ge3", {31'd0, gap >= 3}, 32'd1);
      last_gap      = gap;
      last_wren_cyc = cyc;
    end
    if (serial_rden_out) rden_cnt++;
    if (rd_req_q) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got response %0h expected none (cycle %0d)", {cpu_rd_valid, cpu_rd_data}, cyc);
      end else begin
        e_rd = exp_rd.pop_front();
        chk("rd_resp", {23'd0, cpu_rd_valid, cpu_rd_data}, {23'd0, e_rd});
      end
    end else if (cpu_rd_valid) begin
      checks++;
      errors++;
      $display("FAIL rd_spurious: got valid=1 expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    int base;
    reset = 1'b1; cpu_wr_en = 1'b0; cpu_wr_data = 8'h00; cpu_rd_en = 1'b0;
    clr_drop = 1'b0; serial_in = 8'h00; serial_valid_in = 1'b0; serial_ready_in = 1'b0;
    step(2);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_drop", tx_drop, 0);
    chk("rst_rd_valid", cpu_rd_valid, 0);
    chk("rst_rd_data", cpu_rd_data, 0);
    chk("rst_serial_out", serial_out, 0);
    chk("rst_rden", serial_rden_out, 0);
    chk("rst_wren", serial_wren_out, 0);
    reset = 1'b0;
    step(1);

    // Two bytes with sink ready: strobes exactly 3 cycles apart.
    serial_ready_in = 1'b1;
    exp_tx.push_back(8'h48);
    exp_tx.push_back(8'h69);
    cpu_wr_en = 1'b1; cpu_wr_data = 8'h48; step(1);
    cpu_wr_data = 8'h69; step(1);
    cpu_wr_en = 1'b0;
    step(10);
    chk("tx_pair_gap", last_gap, 3);
    chk("tx_pair_count", tx_count, 0);
    chk("tx_pair_drained", exp_tx.size(), 0);

    // Nine writes with sink stalled: eight stored, one dropped.
    serial_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpu_wr_en = 1'b1; cpu_wr_data = 8'(i);
      if (i < 8) exp_tx.push_back(8'(i));
      step(1);
      if (i == 0) chk("tx_count_next_cycle", tx_count, 1);
    end
    cpu_wr_en = 1'b0;
    chk("tx_full_count", tx_count, 8);
    chk("tx_drop_set", tx_drop, 1);
    clr_drop = 1'b1; step(1); clr_drop = 1'b0;
    chk("tx_drop_clr", tx_drop, 0);
    cpu_wr_en = 1'b1; cpu_wr_data = 8'hF0; clr_drop = 1'b1; step(1);
    cpu_wr_en = 1'b0; clr_drop = 1'b0;
    chk("tx_drop_set_wins", tx_drop, 1);
    chk("tx_full_hold", tx_count, 8);
    // Write while full in the same cycle as the TX pop is still dropped.
    clr_drop = 1'b1; serial_ready_in = 1'b1; step(1);
    clr_drop = 1'b0; cpu_wr_en = 1'b1; cpu_wr_data = 8'hEE; step(1);
    cpu_wr_en = 1'b0;
    chk("tx_drop_on_pop", tx_drop, 1);
    chk("tx_count_after_pop", tx_count, 7);
    step(30);
    chk("tx_drain_count", tx_count, 0);
    chk("tx_drain_all", exp_tx.size(), 0);
    clr_drop = 1'b1; step(1); clr_drop = 1'b0;
    serial_ready_in = 1'b0;

    // RX fill from a constantly valid source until backpressure.
    base = rden_cnt;
    serial_in = 8'h5A; serial_valid_in = 1'b1;
    step(30);
    chk("rx_fill_pulses", rden_cnt - base, 8);
    chk("rx_fill_count", rx_count, 8);
    step(6);
    chk("rx_backpressure", rden_cnt - base, 8);
    cpu_rd_en = 1'b1; exp_rd.push_back({1'b1, 8'h5A}); step(1);
    cpu_rd_en = 1'b0;
    chk("rx_count_after_read", rx_count, 7);
    step(5);
    chk("rx_refill_pulse", rden_cnt - base, 9);
    chk("rx_refill_count", rx_count, 8);

    // Drain RX, then one read on empty.
    serial_valid_in = 1'b0;
    step(3);
    for (int i = 0; i < 8; i++) begin
      cpu_rd_en = 1'b1; exp_rd.push_back({1'b1, 8'h5A}); step(1);
    end
    exp_rd.push_back({1'b0, 8'h00}); step(1);
    cpu_rd_en = 1'b0; step(1);
    chk("rx_empty_count", rx_count, 0);

    // Push and CPU read on an empty RX FIFO in the same cycle.
    serial_in = 8'hC3; serial_valid_in = 1'b1; step(1);
    serial_valid_in = 1'b0; cpu_rd_en = 1'b1; exp_rd.push_back({1'b0, 8'h00}); step(1);
    cpu_rd_en = 1'b0;
    chk("rx_push_on_empty_read", rx_count, 1);
    step(2);
    cpu_rd_en = 1'b1; exp_rd.push_back({1'b1, 8'hC3}); step(1);
    cpu_rd_en = 1'b0; step(1);
    chk("rx_c3_drained", rx_count, 0);
    chk("rd_all_seen", exp_rd.size(), 0);

    // Reset during TX_PUSH with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      cpu_wr_en = 1'b1; cpu_wr_data = 8'hA1 + 8'(i); step(1);
    end
    cpu_wr_en = 1'b0;
    chk("tx_three_queued", tx_count, 3);
    exp_tx.push_back(8'hA1);
    serial_ready_in = 1'b1; step(1);
    reset = 1'b1; step(1);
    reset = 1'b0;
    chk("rst_mid_tx_count", tx_count, 0);
    chk("rst_mid_wren", serial_wren_out, 0);
    chk("rst_mid_serial_out", serial_out, 0);
    step(12);
    chk("rst_mid_no_more_tx", exp_tx.size(), 0);
    chk("rst_mid_tx_idle_count", tx_count, 0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
